// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings and helpers for the load/store front-end
//
// Purpose: funct3 size/sign encodings, the access FSM state type, data memory
// geometry and small decode helpers shared by mem_access_unit and lane_align.
// Ports: none (package).
package mem_pkg;

  localparam int MEM_WORDS = 64;
  localparam int MEM_AW    = 6;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RDW,
    WR,
    RESP
  } state_t;

  // BU/HU only exist as loads; every other unlisted code is illegal.
  function automatic logic f3_legal(input logic [2:0] f3, input logic we);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !we;
      default:          return 1'b0;
    endcase
  endfunction

  // Halfword must sit on an even byte, word on a multiple of four.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lane);
    case (f3[1:0])
      2'b01:   return lane[0];
      2'b10:   return lane != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lane_align.sv
// rtl/lane_align.sv - byte-lane extraction/extension and store merge
//
// Purpose: purely combinational lane steering for a little-endian 32-bit word.
// Low address bits that do not fit the access size are ignored (halfword uses
// lane[1] only, word ignores the lane), so misaligned requests are masked.
// Ports:
//   word       in  32  word read from memory
//   lane       in  2   byte address bits [1:0]
//   funct3     in  3   size in [1:0] (00 B, 01 H, 10 W), [2]=1 zero-extend
//   wdata      in  32  right-aligned store data
//   load_data  out 32  selected and extended load value
//   store_word out 32  word with store data merged at the lane
module lane_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel   = word[{lane, 3'b000} +: 8];
    half_sel   = lane[1] ? word[31:16] : word[15:0];
    load_data  = word;
    store_word = word;
    case (funct3[1:0])
      2'b00: begin
        load_data = funct3[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        store_word[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      2'b01: begin
        load_data = funct3[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
        if (lane[1]) begin
          store_word[31:16] = wdata[15:0];
        end else begin
          store_word[15:0] = wdata[15:0];
        end
      end
      default: begin
        load_data  = word;
        store_word = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - byte-addressed load/store front-end for a 64x32 word memory
//
// Purpose: accepts one request at a time, issues read / read-modify-write /
// write cycles to a synchronous word memory and returns a one-cycle response.
// Optional build macro: MISALIGN_TRAP_EN (misaligned H/W and illegal funct3
// report resp_err=1 without touching memory; otherwise resp_err is tied 0).
// Ports:
//   clk, rst_n                 clock (rising edge), synchronous active-low reset
//   req_valid/req_ready        request handshake, accepted when both are 1
//   req_we, req_funct3         store/load and size/sign code
//   req_addr, req_wdata        byte address and right-aligned store data
//   resp_valid, resp_rdata     completion pulse and extended load data
//   resp_err                   access error
//   mem_read, mem_write        data memory strobes
//   mem_addr, mem_wdata        word address and write data
//   mem_rdata                  data memory read data (registered read)
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t      state;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;
  logic        mem_write_q;
  logic        skip_in;
  logic [31:0] load_data;
  logic [31:0] store_word;

`ifdef MISALIGN_TRAP_EN
  logic err_q;
  assign skip_in  = !f3_legal(req_funct3, req_we) || is_misaligned(req_funct3, req_addr[1:0]);
  assign resp_err = err_q;
`else
  assign skip_in  = !f3_legal(req_funct3, req_we);
  assign resp_err = 1'b0;
`endif

  // Gate the write strobe with reset so a reset landing in WR cannot let the
  // memory commit the half-finished read-modify-write on that same edge.
  assign mem_write = mem_write_q & rst_n;

  lane_align u_lane_align (
    .word       (mem_rdata),
    .lane       (lane_q),
    .funct3     (f3_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      f3_q        <= 3'b000;
      lane_q      <= 2'b00;
      wdata_q     <= '0;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      mem_read    <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
`ifdef MISALIGN_TRAP_EN
      err_q       <= 1'b0;
`endif
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
`ifdef MISALIGN_TRAP_EN
      err_q      <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            f3_q      <= req_funct3;
            lane_q    <= req_addr[1:0];
            wdata_q   <= req_wdata;
            mem_addr  <= MEM_AW'(req_addr[ADDR_W-1:2]);
            req_ready <= 1'b0;
            if (skip_in) begin
              state      <= RESP;
              resp_valid <= 1'b1;
`ifdef MISALIGN_TRAP_EN
              err_q      <= 1'b1;
`endif
            end else if (req_we && req_funct3 == F3_W) begin
              // Full word store needs no read; data goes straight out.
              state       <= WR;
              mem_write_q <= 1'b1;
              mem_wdata   <= req_wdata;
            end else begin
              state    <= RD;
              mem_read <= 1'b1;
            end
          end
        end
        RD: begin
          state <= RDW;
        end
        RDW: begin
          // mem_rdata is valid this cycle; steer it on the way into the registers.
          mem_read <= 1'b0;
          if (we_q) begin
            state       <= WR;
            mem_write_q <= 1'b1;
            mem_wdata   <= store_word;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= load_data;
          end
        end
        WR: begin
          mem_write_q <= 1'b0;
          state       <= RESP;
          resp_valid  <= 1'b1;
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized self-checking bench for mem_access_unit
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem_arr [64];
  logic [31:0] ref_mem [64];
  logic [31:0] last_rdata;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Data memory: synchronous write, registered read.
  initial begin
    for (int i = 0; i < 64; i++) mem_arr[i] = 32'h0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      if (mem_write) mem_arr[mem_addr] <= mem_wdata;
      if (mem_read) mem_rdata <= mem_arr[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) check("rw_exclusive", {31'b0, mem_read & mem_write}, 32'h0);
  end

  function automatic logic [31:0] load_model(input logic [31:0] w, input logic [2:0] f3, input logic [7:0] a);
    logic [31:0] v;
    int sh;
    if (f3[1:0] == 2'b00) begin
      sh = 8 * int'(a[1:0]);
      v = (w >> sh) & 32'hFF;
      if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
    end else if (f3[1:0] == 2'b01) begin
      sh = 16 * int'(a[1]);
      v = (w >> sh) & 32'hFFFF;
      if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] store_model(input logic [31:0] w, input logic [2:0] f3, input logic [7:0] a, input logic [31:0] d);
    logic [31:0] m;
    int sh;
    if (f3[1:0] == 2'b00) begin
      sh = 8 * int'(a[1:0]);
      m = 32'hFF << sh;
      return (w & ~m) | ((d & 32'hFF) << sh);
    end else if (f3[1:0] == 2'b01) begin
      sh = 16 * int'(a[1]);
      m = 32'hFFFF << sh;
      return (w & ~m) | ((d & 32'hFFFF) << sh);
    end
    return d;
  endfunction

  // Issue one request from an idle negedge; returns at the next idle negedge.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [7:0] addr,
                        input logic [31:0] wd, input logic hold);
    int          wi, exp_lat, exp_rd, exp_wr, lat, rd, wr;
    logic        legal, mis, skip, got, exp_err;
    logic [31:0] old_w, new_w, exp_rdata;
    wi      = int'(addr[7:2]);
    old_w   = ref_mem[wi];
    legal   = (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010) || (!we && (f3 == 3'b100 || f3 == 3'b101));
`ifdef MISALIGN_TRAP_EN
    mis     = (f3[1:0] == 2'b01 && addr[0]) || (f3[1:0] == 2'b10 && addr[1:0] != 2'b00);
`else
    mis     = 1'b0;
`endif
    skip    = !legal || mis;
`ifdef MISALIGN_TRAP_EN
    exp_err = skip;
`else
    exp_err = 1'b0;
`endif
    exp_lat   = skip ? 1 : (!we ? 3 : (f3 == 3'b010 ? 2 : 4));
    exp_rd    = (skip || (we && f3 == 3'b010)) ? 0 : 2;
    exp_wr    = (!skip && we) ? 1 : 0;
    exp_rdata = (skip || we) ? 32'h0 : load_model(old_w, f3, addr);
    new_w     = store_model(old_w, f3, addr, wd);

    check("ready_idle", {31'b0, req_ready}, 32'h1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    req_we = 1'($urandom); req_funct3 = 3'($urandom); req_addr = 8'($urandom); req_wdata = $urandom;
    lat = 1; rd = 0; wr = 0; got = 1'b0;
    while (lat <= 8) begin
      if (mem_read) begin
        rd++;
        check("rd_addr", 32'(mem_addr), 32'(wi));
      end
      if (mem_write) begin
        wr++;
        check("wr_addr", 32'(mem_addr), 32'(wi));
        check("wr_data", mem_wdata, new_w);
      end
      if (resp_valid) begin
        got = 1'b1;
        break;
      end
      check("busy_ready", {31'b0, req_ready}, 32'h0);
      @(negedge clk);
      lat++;
    end
    check("resp_seen", {31'b0, got}, 32'h1);
    check("latency", 32'(lat), 32'(exp_lat));
    check("resp_rdata", resp_rdata, exp_rdata);
    check("resp_err", {31'b0, resp_err}, {31'b0, exp_err});
    check("resp_ready", {31'b0, req_ready}, 32'h0);
    check("rd_cycles", 32'(rd), 32'(exp_rd));
    check("wr_cycles", 32'(wr), 32'(exp_wr));
    last_rdata = resp_rdata;
    if (exp_wr == 1) ref_mem[wi] = new_w;
    @(negedge clk);
    check("resp_pulse", {31'b0, resp_valid}, 32'h0);
  endtask

  initial begin
    int wc;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
    last_rdata = 32'h0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0; req_addr = 8'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_err", {31'b0, resp_err}, 32'h0);
    check("rst_mem_read", {31'b0, mem_read}, 32'h0);
    check("rst_mem_write", {31'b0, mem_write}, 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    do_req(1'b1, 3'b010, 8'h08, 32'hDEADBEEF, 1'b0);
    check("sw_mem", mem_arr[2], 32'hDEADBEEF);
    do_req(1'b0, 3'b010, 8'h08, 32'h0, 1'b0);
    check("lw_08", last_rdata, 32'hDEADBEEF);

    do_req(1'b1, 3'b010, 8'h0C, 32'h11223344, 1'b0);
    do_req(1'b1, 3'b000, 8'h0D, 32'h000000AA, 1'b0);
    check("sb_merge", mem_arr[3], 32'h1122AA44);

    do_req(1'b1, 3'b010, 8'h14, 32'h8000FF7F, 1'b0);
    do_req(1'b0, 3'b000, 8'h14, 32'h0, 1'b0); check("lb_14", last_rdata, 32'h0000007F);
    do_req(1'b0, 3'b000, 8'h15, 32'h0, 1'b0); check("lb_15", last_rdata, 32'hFFFFFFFF);
    do_req(1'b0, 3'b100, 8'h15, 32'h0, 1'b0); check("lbu_15", last_rdata, 32'h000000FF);
    do_req(1'b0, 3'b001, 8'h16, 32'h0, 1'b0); check("lh_16", last_rdata, 32'hFFFF8000);
    do_req(1'b0, 3'b101, 8'h16, 32'h0, 1'b0); check("lhu_16", last_rdata, 32'h00008000);

    // Misaligned word load: trapped or masked to word 1 depending on build.
    do_req(1'b1, 3'b010, 8'h04, 32'hCAFEF00D, 1'b0);
    do_req(1'b0, 3'b010, 8'h06, 32'h0, 1'b0);

    // Back-to-back with req_valid held high, including illegal codes.
    do_req(1'b1, 3'b001, 8'h22, 32'h0000BEEF, 1'b1);
    do_req(1'b0, 3'b011, 8'h20, 32'h0, 1'b1);
    do_req(1'b1, 3'b100, 8'h20, 32'h0, 1'b1);
    do_req(1'b0, 3'b001, 8'h22, 32'h0, 1'b1);
    do_req(1'b1, 3'b010, 8'h24, 32'h01020304, 1'b0);

    // Reset during the WR cycle of a byte store: write must be abandoned.
    do_req(1'b1, 3'b010, 8'h1C, 32'h55667788, 1'b0);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 8'h1D; req_wdata = 32'h99;
    @(negedge clk);
    req_valid = 1'b0;
    wc = 0;
    while (!mem_write && wc < 8) begin
      @(negedge clk);
      wc++;
    end
    check("rst_wr_reached", {31'b0, mem_write}, 32'h1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("abort_mem_write", {31'b0, mem_write}, 32'h0);
    check("abort_ready", {31'b0, req_ready}, 32'h1);
    check("abort_resp", {31'b0, resp_valid}, 32'h0);
    check("abort_word", mem_arr[7], 32'h55667788);
    do_req(1'b0, 3'b010, 8'h1C, 32'h0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
             $urandom, 1'($urandom_range(0, 1)));
    end
    req_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      do_req(1'b0, 3'b010, 8'(i * 4), 32'h0, 1'b0);
      check("final_mem", mem_arr[i], ref_mem[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store front-end sitting directly upstream of the word-organised data memory: 64 words x 32 bits, 6-bit word address, mem_read/mem_write strobes, synchronous write.
- Accepts one byte-addressed request at a time from the pipeline and issues the required memory cycles.
- Handles byte and halfword loads with sign or zero extension.
- Performs read-modify-write for byte and halfword stores. Returns a single-cycle response.

Parameters:
- ADDR_W, 8, byte-address width; word index = req_addr[ADDR_W-1:2].
- DATA_W, 32, data word width; fixed at 32, other values are not supported.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle; request accepted when req_valid && req_ready at a rising edge.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result, extended; 0 for stores.
- resp_err  out  1  access error (see Optional Feature).
- mem_read  out  1  to data memory.
- mem_write  out  1  to data memory.
- mem_addr  out  6  word address to data memory.
- mem_wdata  out  32  write data to data memory.
- mem_rdata  in  32  read data from data memory.

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE.
  - Outputs after reset: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
  - Reset mid-operation abandons the access; an in-flight RMW write is not issued.
- All request fields are captured into registers on accept; the inputs are don't-care afterwards.
- FSM states: IDLE, RD, RDW, WR, RESP.
  - IDLE: req_ready=1.
    - On accept: load, SB or SH -> RD; SW -> WR; illegal funct3 -> RESP.
  - RD: mem_read=1, mem_addr=word index -> RDW.
  - RDW: mem_read=1, same address; mem_rdata captured at the end of the cycle.
    - Load -> RESP; sub-word store -> WR.
  - WR: mem_write=1, mem_addr=word index, mem_wdata=merged word -> RESP.
  - RESP: resp_valid=1 for exactly one cycle -> IDLE. There is no back-pressure on the response.
- mem_read and mem_write are never asserted together; both are 0 in IDLE and RESP.
- Latency from accept edge to the resp_valid cycle:
  - LW/LH/LB/LHU/LBU: 3 cycles.
  - SW: 2 cycles.
  - SH/SB: 4 cycles.
  - Illegal funct3: 1 cycle.
- Minimum request spacing equals latency + 1.
- Byte lanes are little-endian: lane = addr[1:0]; halfword uses addr[1].
- Loads: select the lane, then sign-extend (B/H) or zero-extend (BU/HU).
- Stores: merge req_wdata[7:0] or [15:0] into the captured word at the lane; other bytes are preserved.
- Misaligned accesses without the feature: low address bits are masked.
  - H uses addr[1] only.
  - W ignores addr[1:0].
- Illegal funct3 (011, 110, 111, and 100/101 with req_we=1): no memory cycle; resp_rdata=0.

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - Halfword with addr[0]=1 or word with addr[1:0]!=0 skips memory and goes directly to RESP.
  - resp_err=1 and resp_rdata=0 in that cycle.
  - Illegal funct3 also sets resp_err=1.
- Not defined: resp_err is tied 0 and addresses are masked as above.

Decomposition:
- Shared package mem_pkg:
  - funct3 encodings: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - FSM state enum.
  - MEM_WORDS=64, MEM_AW=6.
- One natural sub-module, lane_align (combinational):
  - Load extraction/extension.
  - Store merge given word, lane, size and data.
  - Reusable by a future cache.

Test Plan:
- SW addr=0x08 data=0xDEADBEEF, then LW addr=0x08:
  - mem_write at word 2 one cycle after accept.
  - Load returns 0xDEADBEEF, resp_valid 3 cycles after accept.
- Word 3 = 0x11223344; SB addr=0x0D data=0xAA:
  - RD/RDW at word 3, then WR with 0x1122AA44.
  - resp at 4 cycles after accept.
- Word 5 = 0x8000FF7F:
  - LB 0x14 -> 0x0000007F.
  - LB 0x15 -> 0xFFFFFFFF.
  - LBU 0x15 -> 0x000000FF.
  - LH 0x16 -> 0xFFFF8000.
  - LHU 0x16 -> 0x00008000.
- Back-to-back requests held with req_valid=1:
  - req_ready is 0 outside IDLE; no second accept until after RESP.
  - mem_read and mem_write are never simultaneously 1.
- rst_n=0 during WR of an SB:
  - The next cycle has mem_write=0, req_ready=1, resp_valid=0; word unchanged.
- LW addr=0x06:
  - With MISALIGN_TRAP_EN: resp_err=1, no mem strobes, latency 1.
  - Without: reads word 1, resp_err=0.
